ask_frame_sync: RTL and testbench
=================================

# ask_frame_sync

Bit-to-frame deframer placed directly downstream of the 2ASK receiver's decision stage. It consumes the demodulated bit stream (`data_out`/`data_valid`, one valid pulse per symbol, MSB first) and hunts for a sync word. It then reads a length byte and delivers the payload as bytes over a valid/ready handshake, with end-of-frame status. It is the first byte-level stage of the receive path.

## Interface
- `SYNC_WORD`, 8'hD5: frame sync pattern, compared MSB-first.
- `MAX_LEN`, 16: largest legal payload length in bytes, range 1..255.
- `TIMEOUT`, 400: maximum number of clocks allowed between `bit_valid` pulses while a frame is in progress.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  demodulated bit. Sampled only when `bit_valid` is 1.
- `bit_valid`  in  1  single-cycle strobe, one per symbol.
- `byte_out`  out  8  payload byte.
- `byte_valid`  out  1  `byte_out` is valid. Held high until accepted.
- `byte_ready`  in  1  downstream accepts the byte when both `byte_valid` and `byte_ready` are 1.
- `byte_first`  out  1  qualifies `byte_out` as the first payload byte of the frame.
- `byte_last`  out  1  qualifies `byte_out` as the last payload byte of the frame.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `frame_ok`  out  1  frame status. Valid while `frame_done` is 1, held until the next `frame_done`.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `overflow`  out  1  sticky. Set when a byte is dropped. Cleared only by reset.
- `sync_locked`  out  1  high in every state except HUNT.

## Operation
- States: HUNT, LEN, PAYLOAD, CHK.
- Bit reception:
  - On every `bit_valid`, `bit_in` shifts into an 8-bit shift register, entering at the LSB. The first bit received is therefore the MSB.
  - A 3-bit counter counts bits within the current byte. When the 8th bit arrives, the byte completes using the shift register value that includes that bit.
- HUNT:
  - The bit counter is ignored.
  - On each `bit_valid`, the updated shift register is compared with `SYNC_WORD`.
  - On a match: clear the bit counter and go to LEN.
- LEN: on byte completion, check the length byte L.
  - If L = 0 or L > `MAX_LEN`: pulse `frame_err` and go to HUNT.
  - Otherwise: load the remaining-byte counter with L, seed the running XOR checksum with L, and go to PAYLOAD.
- PAYLOAD: on each byte completion:
  - XOR the byte into the checksum and decrement the remaining-byte counter.
  - Present the byte on the output register. Set `byte_first` for the first payload byte and `byte_last` when the counter reaches 0.
  - After the last byte, go to CHK if `ASK_RX_CHECKSUM_EN` is defined, otherwise to HUNT with `frame_done` = 1 and `frame_ok` = 1.
- CHK: on byte completion:
  - `frame_ok` = (received byte == checksum).
  - Pulse `frame_done` and go to HUNT.
  - The checksum byte is never presented on `byte_out`.
- Output register and overflow:
  - The output register is a single entry.
  - If a byte completes while `byte_valid` = 1 and `byte_ready` = 0, the new byte is dropped, `overflow` is set, and parsing continues.
  - If the dropped byte was the last byte, `byte_last` is lost. `frame_done` still pulses.
- Timeout:
  - In LEN, PAYLOAD, or CHK, an idle counter counts clocks since the last `bit_valid`.
  - When it reaches `TIMEOUT`: pulse `frame_err`, go to HUNT, and clear the bit counter and shift register.
  - The pending output byte is kept.

## Timing
- Reset values: `byte_out` = 0, `byte_valid` = 0, `byte_first` = 0, `byte_last` = 0, `frame_done` = 0, `frame_ok` = 0, `frame_err` = 0, `overflow` = 0, `sync_locked` = 0. State = HUNT and all counters = 0.
- Reset applied mid-frame discards the frame with no `frame_err`. It also drops the pending byte.
- Latency from the 8th `bit_valid` edge:
  - `byte_valid` rises one clock later.
  - `frame_done` and `frame_err` are asserted one clock later, for one cycle.
  - `sync_locked` rises one clock after the matching sync bit.
- Handshake:
  - `byte_valid` falls the cycle after a transfer.
  - If a transfer and a new byte completion occur in the same cycle, the new byte loads and `byte_valid` stays at 1. This is not an overflow.
- The `frame_done` of the last byte may coincide with a pending `byte_valid`.
- The idle counter resets on every `bit_valid`. A `bit_valid` on the timeout cycle takes priority, and no timeout occurs.

## Configuration
- `ASK_RX_CHECKSUM_EN` defined: a trailing XOR checksum byte (L XOR all payload bytes) is received and checked in CHK, and `frame_ok` reflects the result.
- `ASK_RX_CHECKSUM_EN` undefined: the CHK state and checksum logic are removed, frames end after the last payload byte, and `frame_ok` is always 1.

## Test plan
Bits are driven one per 50 clocks with `byte_ready` = 1 unless stated otherwise.
- Send bits of D5, 02, 3C, A1, then (checksum enabled) 9F -> `byte_out` shows 3C with `byte_first` = 1, then A1 with `byte_last` = 1. Then `frame_done` = 1 with `frame_ok` = 1. `byte_out` never shows 9F.
- Same frame with checksum 00 -> `frame_done` = 1 with `frame_ok` = 0. Both payload bytes are still delivered.
- Send noise bits 1101_0100 followed by D5, then length 00 -> `sync_locked` is high only after D5. `frame_err` pulses after the length byte and the state returns to HUNT.
- Send D5, 03, then hold `byte_ready` = 0 for 3 bytes -> the first byte is held, the later bytes are dropped, `overflow` = 1, and `frame_done` still pulses.
- Send D5, 05, one payload byte, then no bits -> `frame_err` pulses exactly 400 clocks after the last `bit_valid`, and `sync_locked` = 0.
- Assert `sys_rst` for 1 cycle in the middle of a payload byte -> all outputs return to reset values and a following complete frame decodes correctly.

Source files
------------

// File: rtl/ask_frame_sync.sv
// Bit-to-frame deframer: hunts SYNC_WORD in the demodulated bit stream, reads a length byte
// and hands payload bytes downstream on valid/ready. Optional trailing checksum: ASK_RX_CHECKSUM_EN.
module ask_frame_sync #(
    parameter logic [7:0] SYNC_WORD = 8'hD5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 400
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_first,
    output logic       byte_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overflow,
    output logic       sync_locked
);

    // Output handshake: byte_out/byte_first/byte_last are stable while byte_valid is high;
    // a transfer happens on any clock where byte_valid && byte_ready, and byte_valid only
    // drops after a transfer (or on reset).

    localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD
`ifdef ASK_RX_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        rem_q, rem_d;
    logic              first_q, first_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              byte_first_q, byte_first_d;
    logic              byte_last_q, byte_last_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              sync_locked_q, sync_locked_d;
`ifdef ASK_RX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [7:0] shift_nxt;
    logic       byte_done;

    assign shift_nxt = {shift_q[6:0], bit_in};
    assign byte_done = bit_valid && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        idle_d        = idle_q;
        rem_d         = rem_q;
        first_d       = first_q;
        byte_out_d    = byte_out_q;
        byte_valid_d  = byte_valid_q;
        byte_first_d  = byte_first_q;
        byte_last_d   = byte_last_q;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        frame_err_d   = 1'b0;
        overflow_d    = overflow_q;
`ifdef ASK_RX_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        if (byte_valid_q && byte_ready) begin
            byte_valid_d = 1'b0;
            byte_first_d = 1'b0;
            byte_last_d  = 1'b0;
        end

        if (bit_valid) begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (state_q == ST_HUNT || bit_valid) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        case (state_q)
            ST_HUNT: begin
                bit_cnt_d = 3'd0;
                if (bit_valid && shift_nxt == SYNC_WORD) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_done) begin
                    if (shift_nxt == 8'd0 || shift_nxt > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else begin
                        rem_d   = shift_nxt;
                        first_d = 1'b1;
`ifdef ASK_RX_CHECKSUM_EN
                        csum_d  = shift_nxt;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_done) begin
`ifdef ASK_RX_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_nxt;
`endif
                    rem_d   = rem_q - 8'd1;
                    first_d = 1'b0;
                    // A byte that finds the single-entry output register still occupied is lost.
                    if (byte_valid_q && !byte_ready) begin
                        overflow_d = 1'b1;
                    end else begin
                        byte_out_d   = shift_nxt;
                        byte_valid_d = 1'b1;
                        byte_first_d = first_q;
                        byte_last_d  = (rem_q == 8'd1);
                    end
                    if (rem_q == 8'd1) begin
`ifdef ASK_RX_CHECKSUM_EN
                        state_d      = ST_CHK;
`else
                        state_d      = ST_HUNT;
                        frame_done_d = 1'b1;
                        frame_ok_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef ASK_RX_CHECKSUM_EN
            ST_CHK: begin
                if (byte_done) begin
                    frame_ok_d   = (shift_nxt == csum_q);
                    frame_done_d = 1'b1;
                    state_d      = ST_HUNT;
                end
            end
`endif
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Bit stream stalled mid-frame; any pending output byte survives.
        if (state_q != ST_HUNT && !bit_valid && idle_q == IDLE_LAST) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            idle_d      = '0;
        end

        sync_locked_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_HUNT;
            shift_q       <= 8'd0;
            bit_cnt_q     <= 3'd0;
            idle_q        <= '0;
            rem_q         <= 8'd0;
            first_q       <= 1'b0;
            byte_out_q    <= 8'd0;
            byte_valid_q  <= 1'b0;
            byte_first_q  <= 1'b0;
            byte_last_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
            sync_locked_q <= 1'b0;
`ifdef ASK_RX_CHECKSUM_EN
            csum_q        <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_q        <= idle_d;
            rem_q         <= rem_d;
            first_q       <= first_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            byte_first_q  <= byte_first_d;
            byte_last_q   <= byte_last_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            overflow_q    <= overflow_d;
            sync_locked_q <= sync_locked_d;
`ifdef ASK_RX_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign byte_first  = byte_first_q;
    assign byte_last   = byte_last_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign sync_locked = sync_locked_q;

endmodule

// File: tb/tb_ask_frame_sync.sv
// Directed bench for ask_frame_sync: framing, length bounds, overflow, timeout and reset.
// Checksum scenarios are included when ASK_RX_CHECKSUM_EN is defined.
module tb_ask_frame_sync;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid, byte_first, byte_last;
    logic       frame_done, frame_ok, frame_err, overflow, sync_locked;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int         done_cnt = 0;
    logic       saw_9f = 1'b0;

    ask_frame_sync dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .sync_locked(sync_locked)
    );

    // Clock / reset
    initial forever #5 clk = ~clk;

    // Monitor: accepted bytes as {first, last, byte}, frame_done pulses, checksum leakage.
    always @(negedge clk) begin
        if (!sys_rst) begin
            if (byte_valid && byte_ready) got_q.push_back({byte_first, byte_last, byte_out});
            if (byte_valid && byte_out == 8'h9F) saw_9f = 1'b1;
            if (frame_done) done_cnt++;
        end
    end

    // Driver tasks: every task starts and ends 1 ns after a rising edge.
    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_byte_nogap(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (i != 0) gap(49);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_byte_nogap(v);
        gap(49);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        gap(2);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        byte_ready = 1'b1;
        do_reset();
        n_cmp++;
        if ({byte_out, byte_valid, byte_first, byte_last, frame_done, frame_ok, frame_err,
             overflow, sync_locked} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_values: got %h %b%b%b%b%b%b%b%b, want all zero", byte_out,
                     byte_valid, byte_first, byte_last, frame_done, frame_ok, frame_err,
                     overflow, sync_locked);
        end
    endtask

    task automatic test_basic_frame();
        int base;
        int dbase;
        do_reset();
        byte_ready = 1'b1;
        base  = got_q.size();
        dbase = done_cnt;
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 8'h3C});
        exp_q.push_back({1'b0, 1'b1, 8'hA1});
        send_byte(8'hD5);
        n_cmp++;
        if (sync_locked !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_locked: got %b want 1", sync_locked);
        end
        send_byte(8'h02);
        send_byte_nogap(8'h3C);
        n_cmp++;
        if ({byte_valid, byte_first, byte_last, byte_out} !== {1'b1, 1'b1, 1'b0, 8'h3C}) begin
            n_bad++;
            $display("FAIL basic_byte0: got v%b f%b l%b %h want v1 f1 l0 3c",
                     byte_valid, byte_first, byte_last, byte_out);
        end
        gap(49);
        send_byte_nogap(8'hA1);
        n_cmp++;
        if ({byte_valid, byte_first, byte_last, byte_out} !== {1'b1, 1'b0, 1'b1, 8'hA1}) begin
            n_bad++;
            $display("FAIL basic_byte1: got v%b f%b l%b %h want v1 f0 l1 a1",
                     byte_valid, byte_first, byte_last, byte_out);
        end
`ifndef ASK_RX_CHECKSUM_EN
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b11) begin
            n_bad++;
            $display("FAIL basic_done: got done%b ok%b want 11", frame_done, frame_ok);
        end
        gap(49);
`else
        gap(49);
        send_byte_nogap(8'h9F);
        n_cmp++;
        if ({frame_done, frame_ok, byte_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL basic_chk_done: got done%b ok%b valid%b want 110",
                     frame_done, frame_ok, byte_valid);
        end
        gap(49);
`endif
        n_cmp++;
        if (got_q.size() - base !== exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d bytes want %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[base + i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL basic_stream[%0d]: got %h want %h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if ({saw_9f, done_cnt - dbase} !== {1'b0, 32'd1}) begin
            n_bad++;
            $display("FAIL basic_tail: saw_9f %b done %0d want 0 and 1", saw_9f, done_cnt - dbase);
        end
    endtask

`ifdef ASK_RX_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base;
        do_reset();
        base = got_q.size();
        send_byte(8'hD5);
        send_byte(8'h02);
        send_byte(8'h3C);
        send_byte(8'hA1);
        send_byte_nogap(8'h00);
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b10) begin
            n_bad++;
            $display("FAIL badchk_done: got done%b ok%b want 10", frame_done, frame_ok);
        end
        gap(49);
        n_cmp++;
        if (got_q.size() - base !== 2) begin
            n_bad++;
            $display("FAIL badchk_count: got %0d bytes want 2", got_q.size() - base);
        end
    endtask
`endif

    task automatic test_len_bound();
        do_reset();
        send_byte(8'hD5);
        send_byte_nogap(8'h11);
        n_cmp++;
        if ({frame_err, sync_locked} !== 2'b10) begin
            n_bad++;
            $display("FAIL len17_err: got err%b lock%b want 10", frame_err, sync_locked);
        end
        gap(49);
    endtask

    task automatic test_noise_then_sync();
        logic [7:0] sw;
        do_reset();
        sw = 8'hD5;
        send_byte(8'hD4);
        n_cmp++;
        if (sync_locked !== 1'b0) begin
            n_bad++;
            $display("FAIL noise_unlocked: got %b want 0", sync_locked);
        end
        for (int i = 7; i >= 1; i--) begin
            send_bit(sw[i]);
            gap(49);
        end
        n_cmp++;
        if (sync_locked !== 1'b0) begin
            n_bad++;
            $display("FAIL noise_prelock: got %b want 0", sync_locked);
        end
        send_bit(sw[0]);
        n_cmp++;
        if (sync_locked !== 1'b1) begin
            n_bad++;
            $display("FAIL noise_lock: got %b want 1", sync_locked);
        end
        gap(49);
        send_byte_nogap(8'h00);
        n_cmp++;
        if ({frame_err, sync_locked} !== 2'b10) begin
            n_bad++;
            $display("FAIL len0_err: got err%b lock%b want 10", frame_err, sync_locked);
        end
        gap(1);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL len0_pulse: got %b want 0", frame_err);
        end
        gap(48);
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] b1;
        do_reset();
        base = got_q.size();
        b1 = 8'hA1;
        byte_ready = 1'b0;
        send_byte(8'hD5);
        send_byte(8'h02);
        send_byte(8'h3C);
        for (int i = 7; i >= 1; i--) begin
            send_bit(b1[i]);
            gap(49);
        end
        byte_ready = 1'b1;
        send_bit(b1[0]);
        n_cmp++;
        if ({byte_valid, byte_first, byte_last, byte_out, overflow} !==
            {1'b1, 1'b0, 1'b1, 8'hA1, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_load: got v%b f%b l%b %h ovf%b want v1 f0 l1 a1 ovf0",
                     byte_valid, byte_first, byte_last, byte_out, overflow);
        end
        gap(49);
`ifdef ASK_RX_CHECKSUM_EN
        send_byte(8'h9F);
`endif
        n_cmp++;
        if (got_q.size() - base !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d bytes want 2", got_q.size() - base);
        end else begin
            n_cmp++;
            if ({got_q[base], got_q[base + 1]} !== {2'b10, 8'h3C, 2'b01, 8'hA1}) begin
                n_bad++;
                $display("FAIL b2b_stream: got %h %h want 23c 1a1", got_q[base], got_q[base + 1]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        byte_ready = 1'b0;
        send_byte(8'hD5);
        send_byte(8'h05);
        send_byte_nogap(8'h7E);
        gap(399);
        n_cmp++;
        if ({frame_err, sync_locked} !== 2'b01) begin
            n_bad++;
            $display("FAIL tmo_early: got err%b lock%b want 01", frame_err, sync_locked);
        end
        gap(1);
        n_cmp++;
        if ({frame_err, sync_locked, byte_valid, byte_out} !== {1'b1, 1'b0, 1'b1, 8'h7E}) begin
            n_bad++;
            $display("FAIL tmo_fire: got err%b lock%b v%b %h want err1 lock0 v1 7e",
                     frame_err, sync_locked, byte_valid, byte_out);
        end
        gap(1);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_pulse: got %b want 0", frame_err);
        end
        byte_ready = 1'b1;
        gap(2);
    endtask

    task automatic test_overflow();
        int dbase;
        do_reset();
        dbase = done_cnt;
        byte_ready = 1'b0;
        send_byte(8'hD5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
`ifdef ASK_RX_CHECKSUM_EN
        send_byte(8'h33);
        send_byte_nogap(8'h03);
`else
        send_byte_nogap(8'h33);
`endif
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b11) begin
            n_bad++;
            $display("FAIL ovf_done: got done%b ok%b want 11", frame_done, frame_ok);
        end
        n_cmp++;
        if ({byte_valid, byte_first, byte_last, byte_out, overflow} !==
            {1'b1, 1'b1, 1'b0, 8'h11, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_hold: got v%b f%b l%b %h ovf%b want v1 f1 l0 11 ovf1",
                     byte_valid, byte_first, byte_last, byte_out, overflow);
        end
        gap(49);
        n_cmp++;
        if (done_cnt - dbase !== 1) begin
            n_bad++;
            $display("FAIL ovf_done_cnt: got %0d want 1", done_cnt - dbase);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        logic [7:0] partial;
        partial = 8'h22;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL mrst_sticky: got %b want 1", overflow);
        end
        send_byte(8'hD5);
        send_byte(8'h03);
        send_byte(8'h11);
        for (int i = 7; i >= 4; i--) begin
            send_bit(partial[i]);
            gap(49);
        end
        sys_rst = 1'b1;
        gap(1);
        sys_rst = 1'b0;
        n_cmp++;
        if ({byte_out, byte_valid, byte_first, byte_last, frame_done, frame_ok, frame_err,
             overflow, sync_locked} !== 16'h0) begin
            n_bad++;
            $display("FAIL mrst_values: got %h %b%b%b%b%b%b%b%b, want all zero", byte_out,
                     byte_valid, byte_first, byte_last, frame_done, frame_ok, frame_err,
                     overflow, sync_locked);
        end
        byte_ready = 1'b1;
        base = got_q.size();
        send_byte(8'hD5);
        send_byte(8'h01);
        send_byte_nogap(8'h5A);
        n_cmp++;
        if ({byte_valid, byte_first, byte_last, byte_out} !== {1'b1, 1'b1, 1'b1, 8'h5A}) begin
            n_bad++;
            $display("FAIL mrst_byte: got v%b f%b l%b %h want v1 f1 l1 5a",
                     byte_valid, byte_first, byte_last, byte_out);
        end
        gap(49);
`ifdef ASK_RX_CHECKSUM_EN
        send_byte_nogap(8'h5B);
`else
        gap(0);
        send_bit(1'b0);
`endif
`ifdef ASK_RX_CHECKSUM_EN
        n_cmp++;
        if ({frame_done, frame_ok} !== 2'b11) begin
            n_bad++;
            $display("FAIL mrst_done: got done%b ok%b want 11", frame_done, frame_ok);
        end
`endif
        gap(49);
        n_cmp++;
        if (got_q.size() - base !== 1) begin
            n_bad++;
            $display("FAIL mrst_count: got %0d bytes want 1", got_q.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
`ifdef ASK_RX_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_len_bound();
        test_noise_then_sync();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
